// File: rtl/key_ctrl_pkg.sv
// Shared definitions for the front-panel key control stage: FSM state
// encoding and default timing constants for the 5 MHz clock domain.
package key_ctrl_pkg;

    localparam logic [1:0] ST_STOP  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_CLEAR = 2'd2;

    localparam int DEF_DB_CYCLES = 50000;
    localparam int DEF_CLR_HOLD  = 5000000;

    typedef enum logic [1:0] {
        S_STOP  = ST_STOP,
        S_RUN   = ST_RUN,
        S_CLEAR = ST_CLEAR
    } key_state_t;

endpackage

// File: rtl/key_debounce.sv
// One push-button: 2-flop synchroniser, stable-level debounce counter and a
// single-cycle pulse on each accepted press (0->1 of the debounced level).
module key_debounce
    import key_ctrl_pkg::*;
#(
    parameter int DB_CYCLES = DEF_DB_CYCLES,
    parameter int DB_W      = 16
) (
    input  logic clk_in1,
    input  logic clr_n,
    input  logic key_raw,
    output logic key_lvl,
    output logic key_press
);

    localparam logic [DB_W-1:0] CNT_MAX = DB_W'(DB_CYCLES - 1);

    logic            r_sync1;
    logic            r_sync2;
    logic            r_lvl;
    logic            r_lvl_d;
    logic [DB_W-1:0] r_cnt;

    always_ff @(posedge clk_in1 or negedge clr_n) begin
        if (!clr_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_lvl   <= 1'b0;
            r_lvl_d <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= key_raw;
            r_sync2 <= r_sync1;
            r_lvl_d <= r_lvl;
            // Any sample agreeing with the stable level restarts the count.
            if (r_sync2 == r_lvl) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_MAX) begin
                r_lvl <= r_sync2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign key_lvl   = r_lvl;
    assign key_press = r_lvl & ~r_lvl_d;

endmodule

// File: rtl/key_ctrl.sv
// Run/stop and clear control for the BCD counter: debounced buttons drive a
// STOP/RUN/CLEAR FSM whose clr output is stretched to span a slow-clock period.
module key_ctrl
    import key_ctrl_pkg::*;
#(
    parameter int DB_CYCLES = DEF_DB_CYCLES,
    parameter int DB_W      = 16,
    parameter int CLR_HOLD  = DEF_CLR_HOLD,
    parameter int HOLD_W    = 23
) (
    input  logic       clk_in1,
    input  logic       clr_n,
    input  logic       btn_run,
    input  logic       btn_clr,
    output logic       Enable,
    output logic       clr,
    output logic [1:0] key_lvl
);

    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(CLR_HOLD - 1);

    logic w_run_lvl;
    logic w_run_press;
    logic w_clr_lvl;
    logic w_clr_press;

    key_state_t        r_state;
    logic [HOLD_W-1:0] r_hold;
    logic              r_enable;
    logic              r_clr;

    key_debounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db_run (
        .clk_in1   (clk_in1),
        .clr_n     (clr_n),
        .key_raw   (btn_run),
        .key_lvl   (w_run_lvl),
        .key_press (w_run_press)
    );

    key_debounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db_clr (
        .clk_in1   (clk_in1),
        .clr_n     (clr_n),
        .key_raw   (btn_clr),
        .key_lvl   (w_clr_lvl),
        .key_press (w_clr_press)
    );

    always_ff @(posedge clk_in1 or negedge clr_n) begin
        if (!clr_n) begin
            r_state  <= S_STOP;
            r_hold   <= '0;
            r_enable <= 1'b0;
            r_clr    <= 1'b0;
        end else begin
            r_enable <= (r_state == S_RUN);
            r_clr    <= (r_state == S_CLEAR);
            case (r_state)
                S_STOP: begin
                    if (w_clr_press) begin
                        r_state <= S_CLEAR;
                        r_hold  <= '0;
                    end else if (w_run_press) begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_clr_press) begin
                        r_state <= S_CLEAR;
                        r_hold  <= '0;
                    end else if (w_run_press) begin
                        r_state <= S_STOP;
                    end
                end
                S_CLEAR: begin
                    // Run presses are dropped; a held clear button keeps H saturated.
                    if (w_clr_press) begin
                        r_hold <= '0;
                    end else if (r_hold == HOLD_MAX) begin
                        if (!w_clr_lvl) begin
                            r_state <= S_STOP;
                        end
                    end else begin
                        r_hold <= r_hold + 1'b1;
                    end
                end
                default: r_state <= S_STOP;
            endcase
        end
    end

    assign Enable  = r_enable;
    assign clr     = r_clr;
    assign key_lvl = {w_clr_lvl, w_run_lvl};

endmodule
